remem_controller: RTL and testbench
===================================

Name: remem_controller

Overview:
- Execute-stage controller for the virtual memristor memory, a 32-row × 32-bit in-memory-computing array.
- Decodes the E-stage instruction and drives the array's row selects, write word/data and logic-gate enables.
- Sequences multi-cycle writes and raises `stall` to freeze the D/E pipeline stages.
- Returns array read/logic results, delayed to line up with the W stage.

Parameters:
- ROWS, 32, number of array rows (row fields are 5 bits; one-hot select width = ROWS).
- XLEN, 32, data/word width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- instruction  in  32  E-stage instruction: [6:0] opcode, [11:7] rd/target row, [19:15] row A, [24:20] row B
- in_data  in  32  E-stage rs1 register value (store data)
- in_buffer_data  in  32  combinational result bus from the array
- out_data_sel_1  out  32  one-hot row A select
- out_data_sel_2  out  32  one-hot row B select
- control  out  32  write data driven onto the columns
- word  out  32  one-hot write-target row
- read_or_gate, and_gate, xor_gate, inv_gate  out  1 each  array gate enables
- stall  out  1  pipeline freeze request
- read_data  out  32  W-aligned result for register write-back

Behaviour:
- Opcodes (shared package): MLW=0x60, MSW=0x61, MOR..MXNOR=0x62..0x67 (OR, AND, XOR, NOR, NAND, XNOR), MORM..MXNORM=0x68..0x6D (same order). Any other opcode: all outputs 0, stall=0, phase held at 0.
- Internal 2-bit phase counter. Outputs are combinational from (opcode, phase). Phase advances each clk while not in the final phase, and returns to 0 after the final phase.
- Gate map for the op types:
  - MLW: read_or_gate.
  - OR / NOR: read_or_gate.
  - AND / NAND: and_gate.
  - XOR / XNOR: xor_gate.
  - NOR / NAND / XNOR: additionally inv_gate.
- READ phase: sel_1 = onehot(row A), sel_2 = onehot(row B), gates per the map. For MLW, sel_1 = onehot(row B) and sel_2 = 0.
- MLW and MOR..MXNOR: single READ phase, stall=0. Result captured at the end of that cycle.
- MSW: two phases.
  - Phase 0 RESET: word = onehot(rd), control = 0, stall = 1.
  - Phase 1 SET: word = onehot(rd), control = in_data, stall = 0.
- MORM..MXNORM: three phases.
  - Phase 0 READ: stall = 1; op_buf <= in_buffer_data at the clock edge.
  - Phase 1 RESET: word = onehot(rd), control = 0, stall = 1.
  - Phase 2 SET: word = onehot(rd), control = op_buf, stall = 0.
- The array writes `control` into the selected row whenever word≠0 and no gate is enabled. During write phases the gates and sel lines are 0.
- Result pipeline:
  - m_data <= in_buffer_data on every clock where a read-type op (MLW, MOR..MXNOR) is in its READ phase; otherwise m_data holds.
  - w_data <= m_data on every clock.
  - read_data = w_data, i.e. a 2-cycle latency matching E→M→W.
- Back-to-back read ops each deliver their own result in consecutive cycles.
- Reset (asynchronous, any time, including mid-sequence):
  - phase, op_buf, m_data, w_data cleared to 0.
  - While rst_n=0, all outputs are forced to 0, including stall.
  - After release, the E-stage instruction restarts at phase 0.
- An instruction change while phase≠0 cannot occur, because the pipeline is stalled. If it happens anyway, phase is reset to 0 and the new instruction starts fresh.

Decomposition:
- Package remem_pkg: opcode constants, phase encodings (PH_READ, PH_RESET, PH_SET), op-class helper function (is_read, is_store, is_mem_op).
- One sub-module: remem_onehot_dec (5→32 one-hot decoder), instantiated for row A, row B and the target row.

Test Plan:
- MLW, row B=5, in_buffer_data=0xDEADBEEF → sel_1=0x00000020, sel_2=0, read_or_gate=1, stall=0; read_data=0xDEADBEEF after 2 clocks.
- MSW, rd=3, in_data=0x12345678 → cycle 1: word=0x8, control=0, stall=1; cycle 2: word=0x8, control=0x12345678, stall=0; phase back to 0.
- MXNORM, rd=7, A=1, B=2, in_buffer_data=0xF0F0F0F0 → cycle 1: sel_1=0x2, sel_2=0x4, xor_gate=1, inv_gate=1, stall=1; cycle 2: word=0x80, control=0, stall=1; cycle 3: word=0x80, control=0xF0F0F0F0, stall=0.
- MAND (in_buffer_data=0x0F) followed immediately by MOR (0xF0) → read_data=0x0F at T+2 and 0xF0 at T+3; read_data holds 0xF0 during following non-memristor cycles.
- rst_n pulsed low during phase 1 of MNANDM → all outputs 0 immediately; after release, the op restarts at the READ phase with stall=1.
- Opcode 0x33 → all selects/word/control/gates 0, stall=0, read_data unchanged.

Source files
------------

// File: rtl/remem_pkg.sv
// Shared definitions for the memristor memory execute-stage controller:
// opcode map, phase encodings and op-class helpers.
package remem_pkg;

  localparam int ROW_W = 5;

  localparam logic [6:0] OP_MLW    = 7'h60;
  localparam logic [6:0] OP_MSW    = 7'h61;
  localparam logic [6:0] OP_MOR    = 7'h62;
  localparam logic [6:0] OP_MAND   = 7'h63;
  localparam logic [6:0] OP_MXOR   = 7'h64;
  localparam logic [6:0] OP_MNOR   = 7'h65;
  localparam logic [6:0] OP_MNAND  = 7'h66;
  localparam logic [6:0] OP_MXNOR  = 7'h67;
  localparam logic [6:0] OP_MORM   = 7'h68;
  localparam logic [6:0] OP_MANDM  = 7'h69;
  localparam logic [6:0] OP_MXORM  = 7'h6A;
  localparam logic [6:0] OP_MNORM  = 7'h6B;
  localparam logic [6:0] OP_MNANDM = 7'h6C;
  localparam logic [6:0] OP_MXNORM = 7'h6D;

  // Phase numbering is shared by all ops; a store's first phase (value 0)
  // is its RESET step, logic-to-memory ops use all three in order.
  typedef enum logic [1:0] {
    PH_READ  = 2'd0,
    PH_RESET = 2'd1,
    PH_SET   = 2'd2
  } phase_e;

  typedef struct packed {
    logic read_or;
    logic and_g;
    logic xor_g;
    logic inv;
  } gates_t;

  // Ops that read (or combine) rows and return a result to the register file.
  function automatic logic is_read(input logic [6:0] op);
    return (op == OP_MLW) || ((op >= OP_MOR) && (op <= OP_MXNOR));
  endfunction

  function automatic logic is_store(input logic [6:0] op);
    return (op == OP_MSW);
  endfunction

  // Logic ops whose result is written back into the array.
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op >= OP_MORM) && (op <= OP_MXNORM);
  endfunction

  // Last phase of each op class; unknown opcodes never leave phase 0.
  function automatic phase_e final_phase(input logic [6:0] op);
    phase_e ph;
    if (is_store(op)) begin
      ph = PH_RESET;
    end else if (is_mem_op(op)) begin
      ph = PH_SET;
    end else begin
      ph = PH_READ;
    end
    return ph;
  endfunction

  // Gate enables used during the read/compute phase of an op.
  function automatic gates_t gate_map(input logic [6:0] op);
    gates_t g;
    g = '{read_or: 1'b0, and_g: 1'b0, xor_g: 1'b0, inv: 1'b0};
    case (op)
      OP_MLW, OP_MOR, OP_MORM:      g.read_or = 1'b1;
      OP_MAND, OP_MANDM:            g.and_g   = 1'b1;
      OP_MXOR, OP_MXORM:            g.xor_g   = 1'b1;
      OP_MNOR, OP_MNORM: begin
        g.read_or = 1'b1;
        g.inv     = 1'b1;
      end
      OP_MNAND, OP_MNANDM: begin
        g.and_g = 1'b1;
        g.inv   = 1'b1;
      end
      OP_MXNOR, OP_MXNORM: begin
        g.xor_g = 1'b1;
        g.inv   = 1'b1;
      end
      default: g = '{read_or: 1'b0, and_g: 1'b0, xor_g: 1'b0, inv: 1'b0};
    endcase
    return g;
  endfunction

endpackage

// File: rtl/remem_onehot_dec.sv
// Row index to one-hot row select decoder.
module remem_onehot_dec
  import remem_pkg::*;
#(
  parameter int ROWS = 32
) (
  input  logic [ROW_W-1:0] idx,
  output logic [ROWS-1:0]  onehot
);

  // Set exactly the bit addressed by idx.
  always_comb begin
    onehot      = {ROWS{1'b0}};
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/remem_controller.sv
// Execute-stage controller for the memristor in-memory-computing array:
// decodes the E-stage instruction, sequences multi-cycle writes with a
// pipeline stall and returns read/logic results aligned to W.
module remem_controller
  import remem_pkg::*;
#(
  parameter int ROWS = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] in_data,
  input  logic [XLEN-1:0] in_buffer_data,
  output logic [ROWS-1:0] out_data_sel_1,
  output logic [ROWS-1:0] out_data_sel_2,
  output logic [XLEN-1:0] control,
  output logic [ROWS-1:0] word,
  output logic            read_or_gate,
  output logic            and_gate,
  output logic            xor_gate,
  output logic            inv_gate,
  output logic            stall,
  output logic [XLEN-1:0] read_data
);

  logic [6:0]       opcode_s;
  logic [ROW_W-1:0] rd_s;
  logic [ROW_W-1:0] ra_s;
  logic [ROW_W-1:0] rb_s;
  logic [ROWS-1:0]  onehot_a_s;
  logic [ROWS-1:0]  onehot_b_s;
  logic [ROWS-1:0]  onehot_rd_s;
  gates_t           gates_s;

  phase_e           phase_r;
  phase_e           phase_s;
  phase_e           phase_nxt_s;
  logic [31:0]      instr_r;
  logic [XLEN-1:0]  op_buf_r;
  logic [XLEN-1:0]  m_data_r;
  logic [XLEN-1:0]  w_data_r;

  assign opcode_s = instruction[6:0];
  assign rd_s     = instruction[11:7];
  assign ra_s     = instruction[19:15];
  assign rb_s     = instruction[24:20];
  assign gates_s  = gate_map(opcode_s);

  remem_onehot_dec #(.ROWS(ROWS)) u_dec_a  (.idx(ra_s), .onehot(onehot_a_s));
  remem_onehot_dec #(.ROWS(ROWS)) u_dec_b  (.idx(rb_s), .onehot(onehot_b_s));
  remem_onehot_dec #(.ROWS(ROWS)) u_dec_rd (.idx(rd_s), .onehot(onehot_rd_s));

  // Effective phase: a new instruction arriving mid-sequence starts fresh.
  always_comb begin
    phase_s = phase_r;
    if ((phase_r != PH_READ) && (instruction != instr_r)) begin
      phase_s = PH_READ;
    end else begin
      phase_s = phase_r;
    end
  end

  // Next phase: step until the op's final phase, then wrap to phase 0.
  always_comb begin
    phase_nxt_s = PH_READ;
    if (phase_s != final_phase(opcode_s)) begin
      case (phase_s)
        PH_READ:  phase_nxt_s = PH_RESET;
        PH_RESET: phase_nxt_s = PH_SET;
        default:  phase_nxt_s = PH_READ;
      endcase
    end else begin
      phase_nxt_s = PH_READ;
    end
  end

  // Phase register and last-seen instruction for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= PH_READ;
      instr_r <= 32'h0000_0000;
    end else begin
      phase_r <= phase_nxt_s;
      instr_r <= instruction;
    end
  end

  // Array drive decode from (opcode, phase); everything low while in reset.
  always_comb begin
    out_data_sel_1 = {ROWS{1'b0}};
    out_data_sel_2 = {ROWS{1'b0}};
    control        = {XLEN{1'b0}};
    word           = {ROWS{1'b0}};
    read_or_gate   = 1'b0;
    and_gate       = 1'b0;
    xor_gate       = 1'b0;
    inv_gate       = 1'b0;
    stall          = 1'b0;
    if (!rst_n) begin
      stall = 1'b0;
    end else if (is_read(opcode_s)) begin
      if (phase_s == PH_READ) begin
        // MLW reads a single row, addressed by the row B field.
        if (opcode_s == OP_MLW) begin
          out_data_sel_1 = onehot_b_s;
        end else begin
          out_data_sel_1 = onehot_a_s;
          out_data_sel_2 = onehot_b_s;
        end
        read_or_gate = gates_s.read_or;
        and_gate     = gates_s.and_g;
        xor_gate     = gates_s.xor_g;
        inv_gate     = gates_s.inv;
      end else begin
        stall = 1'b0;
      end
    end else if (is_store(opcode_s)) begin
      case (phase_s)
        PH_READ: begin
          word  = onehot_rd_s;
          stall = 1'b1;
        end
        PH_RESET: begin
          word    = onehot_rd_s;
          control = in_data;
        end
        default: stall = 1'b0;
      endcase
    end else if (is_mem_op(opcode_s)) begin
      case (phase_s)
        PH_READ: begin
          out_data_sel_1 = onehot_a_s;
          out_data_sel_2 = onehot_b_s;
          read_or_gate   = gates_s.read_or;
          and_gate       = gates_s.and_g;
          xor_gate       = gates_s.xor_g;
          inv_gate       = gates_s.inv;
          stall          = 1'b1;
        end
        PH_RESET: begin
          word  = onehot_rd_s;
          stall = 1'b1;
        end
        PH_SET: begin
          word    = onehot_rd_s;
          control = op_buf_r;
        end
        default: stall = 1'b0;
      endcase
    end else begin
      stall = 1'b0;
    end
  end

  // Hold the logic result of a memory-destined op until its SET phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_buf_r <= {XLEN{1'b0}};
    end else if (is_mem_op(opcode_s) && (phase_s == PH_READ)) begin
      op_buf_r <= in_buffer_data;
    end
  end

  // E->M->W result pipeline; M captures only on a read op's READ phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_r <= {XLEN{1'b0}};
      w_data_r <= {XLEN{1'b0}};
    end else begin
      if (is_read(opcode_s) && (phase_s == PH_READ)) begin
        m_data_r <= in_buffer_data;
      end
      w_data_r <= m_data_r;
    end
  end

  assign read_data = w_data_r;

endmodule

// File: tb/tb_remem_controller.sv
// Directed self-checking bench for remem_controller.
module tb_remem_controller;
  import remem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic [31:0] in_data;
  logic [31:0] in_buffer_data;
  logic [31:0] out_data_sel_1;
  logic [31:0] out_data_sel_2;
  logic [31:0] control;
  logic [31:0] word;
  logic        read_or_gate;
  logic        and_gate;
  logic        xor_gate;
  logic        inv_gate;
  logic        stall;
  logic [31:0] read_data;

  int checks   = 0;
  int failures = 0;

  remem_controller #(.ROWS(32), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instruction    (instruction),
    .in_data        (in_data),
    .in_buffer_data (in_buffer_data),
    .out_data_sel_1 (out_data_sel_1),
    .out_data_sel_2 (out_data_sel_2),
    .control        (control),
    .word           (word),
    .read_or_gate   (read_or_gate),
    .and_gate       (and_gate),
    .xor_gate       (xor_gate),
    .inv_gate       (inv_gate),
    .stall          (stall),
    .read_data      (read_data)
  );

  // 10 ns clock, rising edge active.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] ra, input logic [4:0] rb);
    return {7'd0, rb, ra, 3'd0, rd, op};
  endfunction

  // g = {read_or, and, xor, inv}
  task automatic expect_outs(input string tag, input logic [31:0] s1, input logic [31:0] s2,
                             input logic [31:0] wd, input logic [31:0] ctl,
                             input logic [3:0] g, input logic st);
    check_eq({tag, ".sel1"},  out_data_sel_1, s1);
    check_eq({tag, ".sel2"},  out_data_sel_2, s2);
    check_eq({tag, ".word"},  word, wd);
    check_eq({tag, ".ctl"},   control, ctl);
    check_eq({tag, ".gates"}, {28'd0, read_or_gate, and_gate, xor_gate, inv_gate}, {28'd0, g});
    check_eq({tag, ".stall"}, {31'd0, stall}, {31'd0, st});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    instruction    = mk(OP_MSW, 5'd3, 5'd0, 5'd0);
    in_data        = 32'hFFFF_FFFF;
    in_buffer_data = 32'h0000_0000;

    // Reset: outputs forced low even with a store presented
    tick(); #1;
    expect_outs("rst", 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0);
    check_eq("rst.rdata", read_data, 32'h0);
    rst_n       = 1'b1;
    instruction = 32'h0;

    // MLW row B = 5
    tick();
    instruction    = mk(OP_MLW, 5'd0, 5'd9, 5'd5);
    in_buffer_data = 32'hDEAD_BEEF;
    #1 expect_outs("mlw", 32'h0000_0020, 32'h0, 32'h0, 32'h0, 4'b1000, 1'b0);
    tick();
    instruction    = 32'h0;
    in_buffer_data = 32'h0;
    #1 check_eq("mlw.rdata_t1", read_data, 32'h0);
    tick(); #1 check_eq("mlw.rdata_t2", read_data, 32'hDEAD_BEEF);

    // MSW rd = 3
    tick();
    instruction = mk(OP_MSW, 5'd3, 5'd0, 5'd0);
    in_data     = 32'h1234_5678;
    #1 expect_outs("msw.reset", 32'h0, 32'h0, 32'h8, 32'h0, 4'b0000, 1'b1);
    tick(); #1 expect_outs("msw.set", 32'h0, 32'h0, 32'h8, 32'h1234_5678, 4'b0000, 1'b0);
    tick(); #1 expect_outs("msw.wrap", 32'h0, 32'h0, 32'h8, 32'h0, 4'b0000, 1'b1);
    // new instruction while phase 1: starts fresh at phase 0
    tick();
    instruction = mk(OP_MSW, 5'd4, 5'd0, 5'd0);
    in_data     = 32'hCAFE_F00D;
    #1 expect_outs("msw.chg", 32'h0, 32'h0, 32'h10, 32'h0, 4'b0000, 1'b1);
    tick(); #1 expect_outs("msw.chg_set", 32'h0, 32'h0, 32'h10, 32'hCAFE_F00D, 4'b0000, 1'b0);
    tick();
    instruction = 32'h0;
    #1 expect_outs("nop", 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0);

    // MXNORM rd = 7, A = 1, B = 2
    tick();
    instruction    = mk(OP_MXNORM, 5'd7, 5'd1, 5'd2);
    in_buffer_data = 32'hF0F0_F0F0;
    #1 expect_outs("xnorm.read", 32'h2, 32'h4, 32'h0, 32'h0, 4'b0011, 1'b1);
    tick();
    in_buffer_data = 32'h1111_1111;
    #1 expect_outs("xnorm.reset", 32'h0, 32'h0, 32'h80, 32'h0, 4'b0000, 1'b1);
    tick(); #1 expect_outs("xnorm.set", 32'h0, 32'h0, 32'h80, 32'hF0F0_F0F0, 4'b0000, 1'b0);
    tick();
    instruction = 32'h0;
    #1 check_eq("xnorm.rdata_hold", read_data, 32'hDEAD_BEEF);

    // MAND then MOR back to back, then opcode 0x33
    tick();
    instruction    = mk(OP_MAND, 5'd1, 5'd6, 5'd7);
    in_buffer_data = 32'h0000_000F;
    #1 expect_outs("mand", 32'h40, 32'h80, 32'h0, 32'h0, 4'b0100, 1'b0);
    check_eq("mand.rdata_prev", read_data, 32'hDEAD_BEEF);
    tick();
    instruction    = mk(OP_MOR, 5'd1, 5'd6, 5'd7);
    in_buffer_data = 32'h0000_00F0;
    #1 expect_outs("mor", 32'h40, 32'h80, 32'h0, 32'h0, 4'b1000, 1'b0);
    tick();
    instruction    = mk(7'h33, 5'd5, 5'd6, 5'd7);
    in_buffer_data = 32'h5555_5555;
    #1 expect_outs("op33", 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0);
    check_eq("mand.rdata", read_data, 32'h0000_000F);
    tick(); #1 check_eq("mor.rdata", read_data, 32'h0000_00F0);
    tick(); #1 check_eq("op33.rdata_hold", read_data, 32'h0000_00F0);

    // MNANDM rd = 2, A = 3, B = 4, reset during phase 1
    tick();
    instruction    = mk(OP_MNANDM, 5'd2, 5'd3, 5'd4);
    in_buffer_data = 32'hAAAA_5555;
    #1 expect_outs("nandm.read", 32'h8, 32'h10, 32'h0, 32'h0, 4'b0101, 1'b1);
    tick();
    in_buffer_data = 32'h0;
    #1 expect_outs("nandm.reset", 32'h0, 32'h0, 32'h4, 32'h0, 4'b0000, 1'b1);
    rst_n = 1'b0;
    #1 expect_outs("nandm.in_rst", 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0);
    check_eq("nandm.rst_rdata", read_data, 32'h0);
    #1 rst_n = 1'b1;
    in_buffer_data = 32'h3C3C_3C3C;
    #1 expect_outs("nandm.restart", 32'h8, 32'h10, 32'h0, 32'h0, 4'b0101, 1'b1);
    tick();
    in_buffer_data = 32'h0;
    #1 expect_outs("nandm.reset2", 32'h0, 32'h0, 32'h4, 32'h0, 4'b0000, 1'b1);
    tick(); #1 expect_outs("nandm.set2", 32'h0, 32'h0, 32'h4, 32'h3C3C_3C3C, 4'b0000, 1'b0);
    tick();
    instruction = 32'h0;
    #1 check_eq("nandm.rdata", read_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
